// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD window writer: controller command words,
// FSM state encoding and the pixel-count width.
package lcd_pkg;

  localparam int PIX_CNT_W = 15;

  localparam logic [8:0] CMD_PASET = 9'h02B;
  localparam logic [8:0] CMD_CASET = 9'h02A;
  localparam logic [8:0] CMD_RAMWR = 9'h02C;

  typedef enum logic [3:0] {
    IDLE,
    PASET,
    Y0,
    Y1,
    CASET,
    X0,
    X1,
    RAMWR,
    PIX,
    DONE
  } lcd_state_e;

  // Pixels in an inclusive window; bounds are already known to be ordered.
  function automatic logic [PIX_CNT_W-1:0] pix_count(input logic [7:0] x0,
                                                     input logic [7:0] x1,
                                                     input logic [7:0] y0,
                                                     input logic [7:0] y1);
    logic [8:0]  w;
    logic [8:0]  h;
    logic [17:0] p;
    w = {1'b0, x1} - {1'b0, x0} + 9'd1;
    h = {1'b0, y1} - {1'b0, y0} + 9'd1;
    p = {9'd0, w} * {9'd0, h};
    return p[PIX_CNT_W-1:0];
  endfunction

endpackage

// File: rtl/lcd_word_issuer.sv
// Launches 9-bit words to the SPI master: registers word and strobe, and
// holds off further issue until the master's idle flag can be trusted again.
module lcd_word_issuer #(
  parameter int P_GUARD = 2
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iSpiIdle,
  input  logic       issue,
  input  logic [8:0] word,
  output logic       can_issue,
  output logic [8:0] oSpiWord,
  output logic       oSpiStrobe
);

  localparam int                 GUARD_W    = $clog2(P_GUARD + 2);
  localparam logic [GUARD_W-1:0] GUARD_LOAD = GUARD_W'(P_GUARD + 1);

  logic [GUARD_W-1:0] guard_q;
  logic               fire;

  // The strobe cycle itself is blocked, then P_GUARD further cycles, so the
  // master has seen the strobe before its idle flag is sampled again.
  assign can_issue = iSpiIdle && (guard_q == '0);
  assign fire      = issue && can_issue;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      guard_q    <= '0;
      oSpiWord   <= '0;
      oSpiStrobe <= 1'b0;
    end else begin
      // NOTE: registered state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      oSpiStrobe <= fire;
      if (fire) begin
        oSpiWord <= word;
        guard_q  <= GUARD_LOAD;
      end else if (guard_q != '0) begin
        guard_q <= guard_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/lcd_window_writer.sv
// Writes a rectangular window to an LCD controller: PASET/CASET/RAMWR then N pixels.
// Define LCD_WIN_FILL_EN to add iFill/iFillColor for solid-colour fills.
module lcd_window_writer
  import lcd_pkg::*;
#(
  parameter int P_MAX_COORD = 131,
  parameter int P_GUARD     = 2
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iStart,
  input  logic [7:0] iX0,
  input  logic [7:0] iX1,
  input  logic [7:0] iY0,
  input  logic [7:0] iY1,
`ifdef LCD_WIN_FILL_EN
  input  logic       iFill,
  input  logic [7:0] iFillColor,
`endif
  input  logic [7:0] iPixData,
  input  logic       iPixValid,
  output logic       oPixReady,
  output logic [8:0] oSpiWord,
  output logic       oSpiStrobe,
  input  logic       iSpiIdle,
  output logic       oBusy,
  output logic       oDone,
  output logic       oErr
);

  lcd_state_e           state_q, state_d;
  logic [7:0]           x0_q, x1_q, y0_q, y1_q;
  logic [PIX_CNT_W-1:0] pix_left_q;
  logic                 err_q, err_d;
  logic                 can_issue, issue, pix_ready;
  logic [8:0]           word;
  logic                 bounds_ok, start_ok;
  logic                 fill_active;
  logic [7:0]           fill_color;

  // X0<=X1 and Y0<=Y1 make the upper bounds the only ones to range-check.
  assign bounds_ok = (iX0 <= iX1) && (iY0 <= iY1) &&
                     (int'(iX1) <= P_MAX_COORD) && (int'(iY1) <= P_MAX_COORD);
  assign start_ok  = (state_q == IDLE) && iStart && bounds_ok;

`ifdef LCD_WIN_FILL_EN
  logic       fill_q;
  logic [7:0] fill_color_q;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      fill_q       <= 1'b0;
      fill_color_q <= '0;
    end else if (start_ok) begin
      fill_q       <= iFill;
      fill_color_q <= iFillColor;
    end
  end

  assign fill_active = fill_q;
  assign fill_color  = fill_color_q;
`else
  assign fill_active = 1'b0;
  assign fill_color  = 8'h00;
`endif

  lcd_word_issuer #(
    .P_GUARD(P_GUARD)
  ) u_issuer (
    .iClk      (iClk),
    .iRst      (iRst),
    .iSpiIdle  (iSpiIdle),
    .issue     (issue),
    .word      (word),
    .can_issue (can_issue),
    .oSpiWord  (oSpiWord),
    .oSpiStrobe(oSpiStrobe)
  );

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q    <= IDLE;
      x0_q       <= '0;
      x1_q       <= '0;
      y0_q       <= '0;
      y1_q       <= '0;
      pix_left_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (start_ok) begin
        x0_q       <= iX0;
        x1_q       <= iX1;
        y0_q       <= iY0;
        y1_q       <= iY1;
        pix_left_q <= pix_count(iX0, iX1, iY0, iY1);
      end else if (issue && can_issue && (state_q == PIX)) begin
        pix_left_q <= pix_left_q - 1'b1;
      end
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can infer a latch.
    state_d   = state_q;
    err_d     = 1'b0;
    issue     = 1'b0;
    word      = '0;
    pix_ready = 1'b0;

    case (state_q)
      IDLE: begin
        if (iStart) begin
          if (bounds_ok) state_d = PASET;
          else           err_d   = 1'b1;
        end
      end
      PASET: begin
        word  = CMD_PASET;
        issue = can_issue;
        if (can_issue) state_d = Y0;
      end
      Y0: begin
        word  = {1'b1, y0_q};
        issue = can_issue;
        if (can_issue) state_d = Y1;
      end
      Y1: begin
        word  = {1'b1, y1_q};
        issue = can_issue;
        if (can_issue) state_d = CASET;
      end
      CASET: begin
        word  = CMD_CASET;
        issue = can_issue;
        if (can_issue) state_d = X0;
      end
      X0: begin
        word  = {1'b1, x0_q};
        issue = can_issue;
        if (can_issue) state_d = X1;
      end
      X1: begin
        word  = {1'b1, x1_q};
        issue = can_issue;
        if (can_issue) state_d = RAMWR;
      end
      RAMWR: begin
        word  = CMD_RAMWR;
        issue = can_issue;
        if (can_issue) state_d = PIX;
      end
      PIX: begin
        if (pix_left_q != '0) begin
          if (fill_active) begin
            word  = {1'b1, fill_color};
            issue = can_issue;
          end else begin
            word      = {1'b1, iPixData};
            pix_ready = can_issue;
            issue     = can_issue && iPixValid;
          end
        end else if (can_issue) begin
          // Last pixel has left the master: the window is complete.
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign oPixReady = pix_ready;
  assign oBusy     = (state_q != IDLE);
  assign oDone     = (state_q == DONE);
  assign oErr      = err_q;

endmodule

// File: tb/tb_lcd_window_writer.sv
// Directed self-checking bench for lcd_window_writer with a simple SPI master
// model that stays busy for a few cycles after each strobe.
module tb_lcd_window_writer;

  localparam int P_GUARD = 2;

  logic       iClk = 1'b0;
  logic       iRst;
  logic       iStart;
  logic [7:0] iX0, iX1, iY0, iY1;
  logic [7:0] iPixData;
  logic       iPixValid;
  logic       iSpiIdle;
  logic       oPixReady;
  logic [8:0] oSpiWord;
  logic       oSpiStrobe;
  logic       oBusy, oDone, oErr;
`ifdef LCD_WIN_FILL_EN
  logic       iFill;
  logic [7:0] iFillColor;
`endif

  int n_checks = 0;
  int n_errors = 0;

  int   spi_lat  = 3;
  logic spi_hold = 1'b0;
  logic hold_chk = 1'b0;
  int   busy_cnt;

  logic [8:0] words_q[$];
  logic [8:0] exp_q[$];
  int strobe_cnt = 0, done_cnt = 0, err_cnt = 0, busy_cyc = 0, ready_cyc = 0;
  int gap_viol = 0, hold_viol = 0;
  int cyc = 0, last_strobe = -1000;

  lcd_window_writer #(
    .P_MAX_COORD(131),
    .P_GUARD    (P_GUARD)
  ) dut (
    .iClk      (iClk),
    .iRst      (iRst),
    .iStart    (iStart),
    .iX0       (iX0),
    .iX1       (iX1),
    .iY0       (iY0),
    .iY1       (iY1),
`ifdef LCD_WIN_FILL_EN
    .iFill     (iFill),
    .iFillColor(iFillColor),
`endif
    .iPixData  (iPixData),
    .iPixValid (iPixValid),
    .oPixReady (oPixReady),
    .oSpiWord  (oSpiWord),
    .oSpiStrobe(oSpiStrobe),
    .iSpiIdle  (iSpiIdle),
    .oBusy     (oBusy),
    .oDone     (oDone),
    .oErr      (oErr)
  );

  always #5 iClk = ~iClk;

  // SPI master model: goes busy for spi_lat cycles once it sees a strobe.
  always @(posedge iClk or posedge iRst) begin
    if (iRst)                busy_cnt <= 0;
    else if (oSpiStrobe)     busy_cnt <= spi_lat;
    else if (busy_cnt != 0)  busy_cnt <= busy_cnt - 1;
  end
  assign iSpiIdle = !spi_hold && (busy_cnt == 0);

  // Output monitor, sampled mid-cycle.
  always @(negedge iClk) begin
    cyc <= cyc + 1;
    if (oSpiStrobe) begin
      words_q.push_back(oSpiWord);
      strobe_cnt <= strobe_cnt + 1;
      if (cyc - last_strobe <= P_GUARD) gap_viol <= gap_viol + 1;
      last_strobe <= cyc;
    end
    if (oDone)     done_cnt  <= done_cnt + 1;
    if (oErr)      err_cnt   <= err_cnt + 1;
    if (oBusy)     busy_cyc  <= busy_cyc + 1;
    if (oPixReady) ready_cyc <= ready_cyc + 1;
    if (hold_chk && (oSpiStrobe || oPixReady)) hold_viol <= hold_viol + 1;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge iClk);
    #1;
  endtask

  task automatic start_window(input logic [7:0] x0, input logic [7:0] x1,
                              input logic [7:0] y0, input logic [7:0] y1);
    iX0    = x0;
    iX1    = x1;
    iY0    = y0;
    iY1    = y1;
    iStart = 1'b1;
    tick(1);
    iStart = 1'b0;
  endtask

  function automatic logic [7:0] pix_val(input logic [7:0] seed, input int k);
    logic [31:0] t;
    t = 32'(seed) + 32'(17 * (k + 1));
    return t[7:0];
  endfunction

  task automatic build_exp(input logic [7:0] x0, input logic [7:0] x1,
                           input logic [7:0] y0, input logic [7:0] y1,
                           input logic [7:0] seed, input int n);
    exp_q.delete();
    exp_q.push_back(9'h02B);
    exp_q.push_back({1'b1, y0});
    exp_q.push_back({1'b1, y1});
    exp_q.push_back(9'h02A);
    exp_q.push_back({1'b1, x0});
    exp_q.push_back({1'b1, x1});
    exp_q.push_back(9'h02C);
    for (int k = 0; k < n; k++) exp_q.push_back({1'b1, pix_val(seed, k)});
  endtask

  task automatic compare_words(input string tag, input int base);
    check({tag, "_count"}, words_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (base + i < words_q.size())
        check($sformatf("%s_w%0d", tag, i), words_q[base + i], exp_q[i]);
  endtask

  // Presents pixels first..first+n-1 with valid held high; stops after n accepts.
  task automatic feed(input int first, input int n, input logic [7:0] seed,
                      input int budget);
    int   k;
    int   c;
    logic acc;
    k = first;
    c = 0;
    iPixValid = 1'b1;
    iPixData  = pix_val(seed, k);
    while (k < first + n && c < budget) begin
      @(negedge iClk);
      acc = oPixReady;
      tick(1);
      c++;
      if (acc) begin
        k++;
        iPixData = pix_val(seed, k);
      end
    end
    check($sformatf("pix_fed_from_%0d", first), k - first, n);
  endtask

  task automatic wait_done(input int d0, input int budget);
    int c;
    c = 0;
    while (done_cnt == d0 && c < budget) begin
      tick(1);
      c++;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_word"},   oSpiWord,   0);
    check({tag, "_strobe"}, oSpiStrobe, 0);
    check({tag, "_ready"},  oPixReady,  0);
    check({tag, "_busy"},   oBusy,      0);
    check({tag, "_done"},   oDone,      0);
    check({tag, "_err"},    oErr,       0);
  endtask

  initial begin
    int base, d0, e0, s0, g0, h0, b0, r0;

    iRst      = 1'b1;
    iStart    = 1'b0;
    iX0       = '0;
    iX1       = '0;
    iY0       = '0;
    iY1       = '0;
    iPixData  = '0;
    iPixValid = 1'b0;
`ifdef LCD_WIN_FILL_EN
    iFill      = 1'b0;
    iFillColor = '0;
`endif
    tick(3);
    check_all_zero("reset");
    iRst = 1'b0;
    tick(2);
    check("idle_busy", oBusy, 0);

    // 2x2 window with a pixel already offered in IDLE and a busy-time iStart.
    iPixValid = 1'b1;
    iPixData  = 8'h11;
    tick(2);
    check("idle_ready_low", oPixReady, 0);
    base = words_q.size();
    d0   = done_cnt;
    e0   = err_cnt;
    start_window(8'd0, 8'd1, 8'd0, 8'd1);
    check("busy_after_start", oBusy, 1);
    tick(2);
    start_window(8'd9, 8'd2, 8'd0, 8'd0);
    feed(0, 4, 8'h00, 400);
    wait_done(d0, 200);
    check("win2x2_done", done_cnt - d0, 1);
    tick(2);
    check("win2x2_busy_end", oBusy, 0);
    check("busy_start_no_err", err_cnt - e0, 0);
    exp_q = '{9'h02B, 9'h100, 9'h101, 9'h02A, 9'h100, 9'h101, 9'h02C,
              9'h111, 9'h122, 9'h133, 9'h144};
    compare_words("win2x2", base);
    iPixValid = 1'b0;

    // Illegal bounds are rejected with a single oErr pulse and no traffic.
    s0 = strobe_cnt;
    e0 = err_cnt;
    b0 = busy_cyc;
    start_window(8'd5, 8'd3, 8'd0, 8'd0);
    check("err_pulse", oErr, 1);
    tick(1);
    check("err_one_cycle", oErr, 0);
    check("err_busy_low", oBusy, 0);
    start_window(8'd0, 8'd0, 8'd0, 8'd132);
    check("err_y1_range", oErr, 1);
    tick(10);
    check("err_no_strobe", strobe_cnt - s0, 0);
    check("err_no_busy", busy_cyc - b0, 0);
    check("err_pulse_count", err_cnt - e0, 2);

    // Single-pixel window.
    base = words_q.size();
    d0   = done_cnt;
    start_window(8'd7, 8'd7, 8'd9, 8'd9);
    feed(0, 1, 8'h40, 200);
    wait_done(d0, 200);
    check("win1x1_done", done_cnt - d0, 1);
    build_exp(8'd7, 8'd7, 8'd9, 8'd9, 8'h40, 1);
    compare_words("win1x1", base);

    // 4x4 window with the SPI master held busy for 50 cycles mid-stream.
    base = words_q.size();
    d0   = done_cnt;
    h0   = hold_viol;
    start_window(8'd2, 8'd5, 8'd10, 8'd13);
    feed(0, 5, 8'h05, 600);
    spi_hold = 1'b1;
    tick(1);
    hold_chk = 1'b1;
    tick(48);
    check("hold_ready_low", oPixReady, 0);
    tick(1);
    hold_chk = 1'b0;
    spi_hold = 1'b0;
    check("hold_quiet", hold_viol - h0, 0);
    feed(5, 11, 8'h05, 800);
    wait_done(d0, 200);
    check("win4x4_done", done_cnt - d0, 1);
    build_exp(8'd2, 8'd5, 8'd10, 8'd13, 8'h05, 16);
    compare_words("win4x4", base);

    // Reset after the third pixel of a 4x4 window, then a fresh window.
    start_window(8'd0, 8'd3, 8'd0, 8'd3);
    feed(0, 3, 8'h80, 400);
    iRst = 1'b1;
    #2;
    check_all_zero("midrst");
    tick(2);
    iRst      = 1'b0;
    iPixValid = 1'b0;
    tick(2);
    check("post_rst_busy", oBusy, 0);
    check("post_rst_word", oSpiWord, 0);
    base = words_q.size();
    d0   = done_cnt;
    start_window(8'd3, 8'd3, 8'd4, 8'd4);
    feed(0, 1, 8'h21, 200);
    wait_done(d0, 200);
    check("after_rst_done", done_cnt - d0, 1);
    build_exp(8'd3, 8'd3, 8'd4, 8'd4, 8'h21, 1);
    compare_words("after_rst", base);

`ifdef LCD_WIN_FILL_EN
    // 2x3 solid fill: six colour words, pixel handshake never used.
    base       = words_q.size();
    d0         = done_cnt;
    r0         = ready_cyc;
    iPixValid  = 1'b1;
    iFill      = 1'b1;
    iFillColor = 8'hE0;
    start_window(8'd0, 8'd1, 8'd0, 8'd2);
    iFill = 1'b0;
    wait_done(d0, 400);
    check("fill_done", done_cnt - d0, 1);
    check("fill_ready_low", ready_cyc - r0, 0);
    build_exp(8'd0, 8'd1, 8'd0, 8'd2, 8'h00, 6);
    for (int i = 7; i < 13; i++) exp_q[i] = 9'h1E0;
    compare_words("fill2x3", base);
    iPixValid = 1'b0;
    tick(2);
`endif

    // Full 132x132 window with valid held high and an always-ready master.
    spi_lat   = 0;
    s0        = strobe_cnt;
    g0        = gap_viol;
    d0        = done_cnt;
    base      = words_q.size();
    iPixValid = 1'b1;
    iPixData  = 8'h5A;
    start_window(8'd0, 8'd131, 8'd0, 8'd131);
    wait_done(d0, 80000);
    check("full_done", done_cnt - d0, 1);
    check("full_strobes", strobe_cnt - s0, 17431);
    check("full_gap", gap_viol - g0, 0);
    if (words_q.size() > base + 6) check("full_ramwr", words_q[base + 6], 9'h02C);
    check("full_last_word", words_q[words_q.size() - 1], 9'h15A);
    iPixValid = 1'b0;
    tick(2);
    check("final_busy", oBusy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lcd_window_writer.md
LCD_WINDOW_WRITER -- requirements
Module: lcd_window_writer

Interface
REQ-001 Parameter P_MAX_COORD, default 131: largest legal row/column address.
REQ-002 Parameter P_GUARD, default 2: idle cycles after each oSpiStrobe before iSpiIdle is sampled again.
REQ-003 iClk  in  1  clock; all logic on rising edge.
REQ-004 iRst  in  1  reset, asynchronous, active-high.
REQ-005 iStart  in  1  one-cycle request to write a window.
REQ-006 iX0, iX1, iY0, iY1  in  8 each  inclusive column/row bounds, sampled on accepted iStart.
REQ-007 iPixData  in  8  RGB332 pixel; iPixValid  in  1  pixel present.
REQ-008 oPixReady  out  1  pixel accepted when iPixValid and oPixReady are both high.
REQ-009 oSpiWord  out  9  {D/C, byte}; D/C = 0 for command, 1 for data.
REQ-010 oSpiStrobe  out  1  one-cycle launch to the 9-bit SPI master.
REQ-011 iSpiIdle  in  1  level, high while the SPI master is idle.
REQ-012 oBusy  out  1  window in progress; oDone  out  1  one-cycle completion pulse; oErr  out  1  one-cycle reject pulse.

Function
REQ-013 FSM states: IDLE, PASET, Y0, Y1, CASET, X0, X1, RAMWR, PIX, DONE.
REQ-014 IDLE + iStart with X0<=X1, Y0<=Y1 and all bounds <=P_MAX_COORD: latch bounds, go to PASET, and raise oBusy next cycle.
REQ-015 IDLE + iStart with any illegal bound: oErr pulses next cycle; state stays IDLE; no SPI word is issued.
REQ-016 Words in order: 0x02B, {1,Y0}, {1,Y1}, 0x02A, {1,X0}, {1,X1}, 0x02C, then N pixel words {1,pix}.
REQ-017 N = (X1-X0+1)*(Y1-Y0+1), held in a 15-bit counter; full 132x132 = 17424 SHALL fit.
REQ-018 A word is issued only when iSpiIdle=1 and the guard counter has expired; oSpiWord updates in the same cycle that oSpiStrobe is high, and oSpiWord holds until the next strobe.
REQ-019 After each strobe, the guard counter blocks issue for P_GUARD cycles, so a stale iSpiIdle is never used.
REQ-020 PIX: oPixReady = iSpiIdle & guard expired & pixels remaining; accepted pixel -> oSpiStrobe with {1,iPixData} on the next cycle.
REQ-021 oPixReady is low in every state other than PIX.
REQ-022 After the Nth pixel is issued and iSpiIdle returns high (post-guard): enter DONE, pulse oDone for 1 cycle, drop oBusy, return to IDLE.
REQ-023 iStart while oBusy is ignored, with no oErr.
REQ-024 iPixValid outside PIX is ignored; no pixel is consumed.
REQ-025 Single-pixel window (X0=X1, Y0=Y1): N=1, 8 words in total.

Reset
REQ-026 iRst asserted at any time, including mid-window: state IDLE; oSpiWord=0; oSpiStrobe, oPixReady, oBusy, oDone and oErr all 0; counters 0.
REQ-027 No partial word resumes after reset; the next window starts again at PASET.

Configuration
REQ-028 Macro LCD_WIN_FILL_EN defined: adds inputs iFill (1) and iFillColor (8).
REQ-029 With LCD_WIN_FILL_EN, iFill=1 on accepted iStart latches iFillColor, and PIX issues N words of {1,color} without using the pixel handshake.
REQ-030 With LCD_WIN_FILL_EN, oPixReady stays 0 during a fill.
REQ-031 LCD_WIN_FILL_EN undefined: iFill and iFillColor are absent, and pixels always come from the handshake.

Structure
REQ-032 Package lcd_pkg holds: command constants CMD_PASET=9'h02B, CMD_CASET=9'h02A, CMD_RAMWR=9'h02C; the state enum type; the pixel-count width constant (15).
REQ-033 Sub-module lcd_word_issuer holds the iSpiIdle/guard/strobe logic and exposes a can_issue/issue pair to the FSM.

Verification
REQ-034 Window X 0..1, Y 0..1 with pixels 0x11,0x22,0x33,0x44 -> words 02B,100,101,02A,100,101,02C,111,122,133,144, then one oDone pulse.
REQ-035 iStart with X0=5, X1=3 -> oErr pulse, zero strobes, oBusy stays 0.
REQ-036 Full 0..131 x 0..131 window with iPixValid held high -> exactly 17431 strobes; no strobe within P_GUARD cycles of the previous one.
REQ-037 iRst pulsed after the 3rd pixel of a 4x4 window -> all outputs 0; a new iStart restarts at 02B.
REQ-038 iSpiIdle held low for 50 cycles mid-stream -> oPixReady low and no strobe until iSpiIdle rises.
REQ-039 LCD_WIN_FILL_EN, iFill=1, color 0xE0, 2x3 window -> 6 words of 1E0, with oPixReady low throughout.
